loop_ctrl_fsm: RTL and testbench

Sequencer that drives the loop counters of the interpolation datapath. It walks a 2-D index pair (I outer, J inner) over a signed range. The default range is -1..2 × -1..2, which is the 4x4 neighbourhood.
- Each counter value is held in an external counter register (reg_counter), one instance for I and one for J.
- This block computes each register's next value and write enable, and reads back its current value.
- It presents one iteration per accepted cycle to the downstream tap/MAC stage through a valid/ready handshake.

---
 rtl/interp_pkg.sv | 19 +
 rtl/loop_ctrl_fsm.sv | 121 ++++++++++++
 tb/tb_loop_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation loop sequencer.
package interp_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_FIN
  } loop_state_t;

  // Default counter width.
  localparam int CNT_W_DEF = 4;

  // Default bounds cover the 4x4 neighbourhood -1..2 on both axes.
  localparam int BOUND_LO = -1;
  localparam int BOUND_HI = 2;

endpackage : interp_pkg

// File: rtl/loop_ctrl_fsm.sv
// Loop sequencer that walks a signed (I outer, J inner) index pair.
// The counter values live in external registers. This block computes their
// next value and write enable, and reads the current value back.
// Each iteration is handed downstream through a valid/ready handshake.
module loop_ctrl_fsm
  import interp_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int I_START = BOUND_LO,
  parameter int I_END   = BOUND_HI,
  parameter int J_START = BOUND_LO,
  parameter int J_END   = BOUND_HI
) (
  input  logic                    CLK,
  input  logic                    RST_SYNC,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic signed [CNT_W-1:0] CNT_I,
  input  logic signed [CNT_W-1:0] CNT_J,
  output logic signed [CNT_W-1:0] CNT_I_NEXT,
  output logic                    CNT_I_WE,
  output logic signed [CNT_W-1:0] CNT_J_NEXT,
  output logic                    CNT_J_WE,
  output logic                    ITER_VALID,
  input  logic                    ITER_READY,
  output logic                    ITER_LAST,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int SMIN = -(2 ** (CNT_W - 1));
  localparam int SMAX = (2 ** (CNT_W - 1)) - 1;

  localparam logic signed [CNT_W-1:0] I_START_C = CNT_W'(I_START);
  localparam logic signed [CNT_W-1:0] I_END_C   = CNT_W'(I_END);
  localparam logic signed [CNT_W-1:0] J_START_C = CNT_W'(J_START);
  localparam logic signed [CNT_W-1:0] J_END_C   = CNT_W'(J_END);
  localparam logic signed [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Reject bounds that are reversed or do not fit the signed counter width.
  if (I_START > I_END || J_START > J_END) begin : g_bad_order
    $error("loop_ctrl_fsm: START must not exceed END");
  end
  if (I_START < SMIN || I_END > SMAX || J_START < SMIN || J_END > SMAX) begin : g_bad_width
    $error("loop_ctrl_fsm: bounds do not fit in CNT_W signed bits");
  end

  loop_state_t r_state;
  loop_state_t w_state_nxt;
  logic        w_last;

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter next values and write enables, handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    CNT_I_NEXT  = '0;
    CNT_I_WE    = 1'b0;
    CNT_J_NEXT  = '0;
    CNT_J_WE    = 1'b0;
    ITER_VALID  = 1'b0;
    ITER_LAST   = 1'b0;
    DONE        = 1'b0;
    BUSY        = (r_state != ST_IDLE);
    w_last      = (CNT_I == I_END_C) && (CNT_J == J_END_C);

    unique case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          CNT_I_WE    = 1'b1;
          CNT_I_NEXT  = I_START_C;
          CNT_J_WE    = 1'b1;
          CNT_J_NEXT  = J_START_C;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        ITER_VALID = 1'b1;
        ITER_LAST  = w_last;
        // ABORT overrides an accepted iteration, so it suppresses all writes.
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (ITER_READY) begin
          if (w_last) begin
            w_state_nxt = ST_FIN;
          end else if (CNT_J != J_END_C) begin
            CNT_J_WE   = 1'b1;
            CNT_J_NEXT = CNT_J + ONE_C;
          end else begin
            CNT_J_WE   = 1'b1;
            CNT_J_NEXT = J_START_C;
            CNT_I_WE   = 1'b1;
            CNT_I_NEXT = CNT_I + ONE_C;
          end
        end
      end
      ST_FIN: begin
        DONE        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : loop_ctrl_fsm

// File: tb/tb_loop_ctrl_fsm.sv
// Self-checking bench for loop_ctrl_fsm: default 4x4 range plus a
// single-point range instance.
module tb_loop_ctrl_fsm;

  localparam int IS = -1;
  localparam int IE = 2;
  localparam int JS = -1;
  localparam int JE = 2;
  localparam int NJ = JE - JS + 1;
  localparam int NT = (IE - IS + 1) * NJ;

  localparam int P_IDLE = 0;
  localparam int P_INIT = 1;
  localparam int P_RUN  = 2;
  localparam int P_FIN  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic              rst = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic signed [3:0] cnt_i, cnt_j, i_next, j_next;
  logic              i_we, j_we, valid, last, busy, done;

  // Single-point DUT signals
  logic              d_rst = 1'b0, d_start = 1'b0, d_abort = 1'b0, d_ready = 1'b0;
  logic signed [3:0] d_cnt_i, d_cnt_j, d_i_next, d_j_next;
  logic              d_i_we, d_j_we, d_valid, d_last, d_busy, d_done;

  loop_ctrl_fsm dut (
    .CLK(clk), .RST_SYNC(rst), .START(start), .ABORT(abort),
    .CNT_I(cnt_i), .CNT_J(cnt_j),
    .CNT_I_NEXT(i_next), .CNT_I_WE(i_we), .CNT_J_NEXT(j_next), .CNT_J_WE(j_we),
    .ITER_VALID(valid), .ITER_READY(ready), .ITER_LAST(last),
    .BUSY(busy), .DONE(done)
  );

  loop_ctrl_fsm #(.CNT_W(4), .I_START(0), .I_END(0), .J_START(1), .J_END(1)) u_deg (
    .CLK(clk), .RST_SYNC(d_rst), .START(d_start), .ABORT(d_abort),
    .CNT_I(d_cnt_i), .CNT_J(d_cnt_j),
    .CNT_I_NEXT(d_i_next), .CNT_I_WE(d_i_we), .CNT_J_NEXT(d_j_next), .CNT_J_WE(d_j_we),
    .ITER_VALID(d_valid), .ITER_READY(d_ready), .ITER_LAST(d_last),
    .BUSY(d_busy), .DONE(d_done)
  );

  // External counter registers (reg_counter behaviour)
  always @(posedge clk) begin
    if (i_we)   cnt_i   <= i_next;
    if (j_we)   cnt_j   <= j_next;
    if (d_i_we) d_cnt_i <= d_i_next;
    if (d_j_we) d_cnt_j <= d_j_next;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sweep phase and index of the current iteration
  int phase = P_IDLE;
  int k     = 0;
  int accepted_i[$];
  int accepted_j[$];

  function automatic int pi(input int idx);
    return IS + idx / NJ;
  endfunction

  function automatic int pj(input int idx);
    return JS + idx % NJ;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle on the main DUT: drive, compare against the model, advance.
  task automatic cycle(input logic st, input logic ab, input logic rd, input logic rs, input bit do_chk);
    int  e_iwe, e_jwe, e_in, e_jn;
    bit  is_last;
    start = st; abort = ab; ready = rd; rst = rs;
    #2;
    is_last = (phase == P_RUN) && (k == NT - 1);
    e_iwe = 0; e_jwe = 0; e_in = 0; e_jn = 0;
    if (phase == P_INIT && !ab) begin
      e_iwe = 1; e_jwe = 1; e_in = IS; e_jn = JS;
    end else if (phase == P_RUN && !ab && rd && !is_last) begin
      e_jwe = 1; e_jn = pj(k + 1);
      e_in  = pi(k + 1);
      e_iwe = (pi(k + 1) != pi(k)) ? 1 : 0;
    end
    if (do_chk) begin
      chk("busy",  busy,  (phase != P_IDLE) ? 1 : 0);
      chk("valid", valid, (phase == P_RUN) ? 1 : 0);
      chk("done",  done,  (phase == P_FIN) ? 1 : 0);
      chk("last",  last,  is_last ? 1 : 0);
      chk("i_we",  i_we,  e_iwe);
      chk("j_we",  j_we,  e_jwe);
      if (e_iwe == 1 || phase == P_IDLE) chk("i_next", i_next, e_in);
      if (e_jwe == 1 || phase == P_IDLE) chk("j_next", j_next, e_jn);
      if (phase == P_RUN) begin
        chk("cnt_i", cnt_i, pi(k));
        chk("cnt_j", cnt_j, pj(k));
      end
    end
    if (phase == P_RUN && rd && !ab && !rs) begin
      accepted_i.push_back(int'(cnt_i));
      accepted_j.push_back(int'(cnt_j));
    end
    @(posedge clk);
    if (rs) phase = P_IDLE;
    else begin
      case (phase)
        P_IDLE: if (st) phase = P_INIT;
        P_INIT: if (ab) phase = P_IDLE; else begin phase = P_RUN; k = 0; end
        P_RUN: begin
          if (ab) phase = P_IDLE;
          else if (rd) begin
            if (k == NT - 1) phase = P_FIN;
            else k = k + 1;
          end
        end
        default: phase = P_IDLE;
      endcase
    end
    #1;
  endtask

  initial begin
    int hold;
    bit st_b, rd_b, ab_b;

    // Reset; the first cycle is not compared because state starts unknown.
    d_rst = 1'b1;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    d_rst = 1'b0;
    cycle(0, 0, 0, 0, 1);

    // Sweep 1: full ready, with 3-cycle backpressure at (0,1) and a START at (0,0)
    accepted_i.delete();
    accepted_j.delete();
    hold = 0;
    cycle(1, 0, 1, 0, 1);
    for (int c = 0; c < 100 && phase != P_IDLE; c++) begin
      rd_b = 1'b1;
      if (phase == P_RUN && k == 6 && hold < 3) begin
        rd_b = 1'b0;
        hold++;
      end
      st_b = (phase == P_RUN && k == 5);
      cycle(st_b, 0, rd_b, 0, 1);
    end
    chk("sweep1_idle_busy", busy, 0);
    chk("sweep1_count", accepted_i.size(), NT);
    for (int a = 0; a < accepted_i.size() && a < NT; a++) begin
      chk("order_i", accepted_i[a], IS + a / NJ);
      chk("order_j", accepted_j[a], JS + a % NJ);
    end

    // Sweep 2: ABORT at (1,0) with ITER_READY high
    cycle(1, 0, 0, 0, 1);
    for (int c = 0; c < 100 && phase != P_IDLE; c++) begin
      ab_b = (phase == P_RUN && k == 9);
      cycle(0, ab_b, 1, 0, 1);
    end
    chk("abort_busy", busy, 0);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 1);

    // Sweep 3: re-init after abort, random backpressure to completion
    cycle(1, 1, 0, 0, 1);
    for (int c = 0; c < 300 && phase != P_IDLE; c++)
      cycle(0, 0, 1'($urandom_range(0, 1)), 0, 1);
    chk("sweep3_end_busy", busy, 0);

    // Reset mid-run
    cycle(1, 0, 0, 0, 1);
    for (int c = 0; c < 5; c++) cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Random sweeps with sporadic ABORT and stray START
    for (int s = 0; s < 6; s++) begin
      cycle(1, 0, 0, 0, 1);
      for (int c = 0; c < 300 && phase != P_IDLE; c++) begin
        ab_b = ($urandom_range(0, 39) == 0);
        st_b = ($urandom_range(0, 7) == 0);
        cycle(st_b, ab_b, 1'($urandom_range(0, 3) != 0), 0, 1);
      end
      chk("rand_sweep_end_busy", busy, 0);
      cycle(0, 0, 0, 0, 1);
    end

    // Single-point range: one iteration (0,1) with ITER_LAST, then DONE
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    #1;
    chk("deg_init_busy", d_busy, 1);
    chk("deg_init_iwe", d_i_we, 1);
    chk("deg_init_jwe", d_j_we, 1);
    chk("deg_init_in", d_i_next, 0);
    chk("deg_init_jn", d_j_next, 1);
    @(posedge clk); #1;
    d_ready = 1'b1;
    #1;
    chk("deg_valid", d_valid, 1);
    chk("deg_last", d_last, 1);
    chk("deg_cnt_i", d_cnt_i, 0);
    chk("deg_cnt_j", d_cnt_j, 1);
    chk("deg_run_iwe", d_i_we, 0);
    chk("deg_run_jwe", d_j_we, 0);
    @(posedge clk); #1;
    d_ready = 1'b0;
    #1;
    chk("deg_done", d_done, 1);
    chk("deg_fin_valid", d_valid, 0);
    @(posedge clk); #2;
    chk("deg_idle_busy", d_busy, 0);
    chk("deg_idle_done", d_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_loop_ctrl_fsm
